fp_add_arbiter: RTL

Shares one multi-cycle floating-point adder (the Control-sequenced add/normalise/round datapath) among NREQ requesters. Each requester offers an operand pair with a valid/ready handshake. A round-robin scheduler grants one requester at a time, pulses the adder's Go, and waits for its done flag (FlagResult). It then returns the sum with the requester ID through a single-entry response buffer, with a timeout guard against a hung adder.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/fp_add_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types for the floating-point adder arbiter: operand layout and scheduler states.
package fp_pkg;

    localparam int EXPBITS      = 8;
    localparam int MANTISSABITS = 23;

    typedef struct packed {
        logic                    sign;
        logic [EXPBITS-1:0]      exp;
        logic [MANTISSABITS-1:0] mant;
    } fp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [IDW-1:0] idx_s;
    logic           sel_s;

    // scan ptr, ptr+1, ... and keep only the first hit
    always_comb begin
        grant_oh  = {NREQ{1'b0}};
        grant_idx = {IDW{1'b0}};
        any       = 1'b0;
        idx_s     = {IDW{1'b0}};
        sel_s     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s           = IDW'((32'(ptr) + k) % NREQ);
            sel_s           = req[idx_s] & ~any;
            grant_oh[idx_s] = grant_oh[idx_s] | sel_s;
            grant_idx       = sel_s ? idx_s : grant_idx;
            any             = any | sel_s;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one multi-cycle FP adder among NREQ requesters with round-robin grants,
// a single-entry response buffer and a timeout abort for a hung adder.
module fp_add_arbiter #(
    parameter int NREQ         = 4,
    parameter int EXPBITS      = fp_pkg::EXPBITS,
    parameter int MANTISSABITS = fp_pkg::MANTISSABITS,
    parameter int TIMEOUT      = 64,
    localparam int W   = 1 + EXPBITS + MANTISSABITS,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              add_go,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic              add_done,
    input  logic [W-1:0]      add_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_result,
    output logic              resp_err,
    output logic              busy
);

    import fp_pkg::arb_state_t;
    import fp_pkg::IDLE;
    import fp_pkg::ISSUE;
    import fp_pkg::WAIT;
    import fp_pkg::RESP;

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t     state_r, state_nxt_s;
    logic [IDW-1:0] ptr_r;
    logic [CW-1:0]  cnt_r;
    logic [W-1:0]   op_a_r, op_b_r;
    logic           resp_valid_r, resp_err_r;
    logic [IDW-1:0] resp_id_r;
    logic [W-1:0]   resp_result_r;
    logic [NREQ-1:0] grant_oh_s;
    logic [IDW-1:0] grant_idx_s;
    logic           any_s;
    logic           timeout_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant_oh  (grant_oh_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    // abort on the edge where the counter would reach TIMEOUT-1, so the error
    // response appears exactly TIMEOUT cycles after the Go pulse
    assign timeout_s = (cnt_r == CW'(TIMEOUT - 2));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) state_nxt_s = ISSUE;
                else       state_nxt_s = IDLE;
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (add_done || timeout_s) state_nxt_s = RESP;
                else                       state_nxt_s = WAIT;
            end
            RESP: begin
                if (resp_ready) state_nxt_s = IDLE;
                else            state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // operand capture, pointer rotation, wait counter and response buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r         <= {IDW{1'b0}};
            cnt_r         <= {CW{1'b0}};
            op_a_r        <= {W{1'b0}};
            op_b_r        <= {W{1'b0}};
            resp_valid_r  <= 1'b0;
            resp_err_r    <= 1'b0;
            resp_id_r     <= {IDW{1'b0}};
            resp_result_r <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        op_a_r    <= req_a[grant_idx_s*W +: W];
                        op_b_r    <= req_b[grant_idx_s*W +: W];
                        resp_id_r <= grant_idx_s;
                        ptr_r     <= (grant_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}}
                                                                     : grant_idx_s + 1'b1;
                    end
                end
                ISSUE: cnt_r <= {CW{1'b0}};
                WAIT: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (add_done) begin
                        resp_result_r <= add_result;
                        resp_err_r    <= 1'b0;
                        resp_valid_r  <= 1'b1;
                    end else if (timeout_s) begin
                        resp_result_r <= {W{1'b0}};
                        resp_err_r    <= 1'b1;
                        resp_valid_r  <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) resp_valid_r <= 1'b0;
                end
                default: resp_valid_r <= 1'b0;
            endcase
        end
    end

    assign req_ready   = (rst_n && state_r == IDLE) ? grant_oh_s : {NREQ{1'b0}};
    assign add_go      = (state_r == ISSUE);
    assign add_a       = op_a_r;
    assign add_b       = op_b_r;
    assign resp_valid  = resp_valid_r;
    assign resp_id     = resp_id_r;
    assign resp_result = resp_result_r;
    assign resp_err    = resp_err_r;
    assign busy        = (state_r != IDLE);

endmodule
